// File: rtl/packet_tx_sched.sv
// rtl/packet_tx_sched.sv - round-robin scheduler sharing one UART packet transmitter among N requesters
module packet_tx_sched #(
  parameter int N            = 4,
  parameter int MAX_LEN      = 32,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_cmd,
  input  logic [16*N-1:0]  req_len,
  input  logic [256*N-1:0] req_payload,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     ack,
  output logic [N-1:0]     err,
  output logic [7:0]       tx_cmd,
  output logic [15:0]      tx_len,
  output logic [255:0]     tx_payload,
  output logic             tx_send,
  input  logic             tx_busy,
  output logic             active
);

  localparam int PW       = (N > 1) ? $clog2(N) : 1;
  localparam int TW       = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW       = $clog2(GAP_CYCLES + 2);
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_START,
    ST_WAIT_END,
    ST_DONE,
    ST_FAIL,
    ST_GAP
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  cand;
  logic [PW-1:0]  win_idx;
  logic           win_found;
  logic [N-1:0]   sel;
  logic [TW-1:0]  to_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [15:0]    win_len;
  logic           len_bad;
  logic           to_expired;
  logic           gap_done;
  logic           granted;

  // Scan upward from the requester after the last winner, wrapping at N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_len    = req_len[{win_idx, 4'b0} +: 16];
  assign len_bad    = {16'd0, win_len} > 32'(MAX_LEN);
  assign to_expired = to_cnt == TW'(BUSY_TIMEOUT - 1);
  assign gap_done   = gap_cnt == GW'(GAP_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (win_found) state_next = len_bad ? ST_FAIL : ST_SEND;
      ST_SEND:       state_next = ST_WAIT_START;
      // Busy takes priority over an expiring counter.
      ST_WAIT_START: begin
        if (tx_busy)         state_next = ST_WAIT_END;
        else if (to_expired) state_next = ST_FAIL;
      end
      ST_WAIT_END:   if (!tx_busy) state_next = ST_DONE;
      ST_DONE:       state_next = ST_GAP;
      ST_FAIL:       state_next = ST_GAP;
      ST_GAP:        if (gap_done) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= PW'(N - 1);
      sel        <= '0;
      tx_cmd     <= '0;
      tx_len     <= '0;
      tx_payload <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      if (state == ST_IDLE && win_found) begin
        ptr        <= win_idx;
        sel        <= N'(1) << win_idx;
        tx_cmd     <= req_cmd[{win_idx, 3'b0} +: 8];
        tx_len     <= win_len;
        tx_payload <= req_payload[{win_idx, 8'b0} +: 256];
      end
      if (state == ST_SEND)            to_cnt <= '0;
      else if (state == ST_WAIT_START) to_cnt <= to_cnt + 1'b1;
      if (state == ST_GAP && !gap_done) gap_cnt <= gap_cnt + 1'b1;
      else                              gap_cnt <= '0;
    end
  end

  assign granted = (state == ST_SEND) || (state == ST_WAIT_START) || (state == ST_WAIT_END) ||
                   (state == ST_DONE) || (state == ST_FAIL);
  assign gnt     = granted ? sel : '0;
  assign ack     = (state == ST_DONE) ? sel : '0;
  assign err     = (state == ST_FAIL) ? sel : '0;
  assign tx_send = state == ST_SEND;
  assign active  = state != ST_IDLE;

endmodule

// File: tb/tb_packet_tx_sched.sv
// tb/tb_packet_tx_sched.sv - self-checking bench for packet_tx_sched
module tb_packet_tx_sched;

  localparam int N   = 4;
  localparam int ML  = 32;
  localparam int BT  = 16;
  localparam int GC  = 4;
  localparam int G   = (GC > 0) ? GC : 1;

  logic             clock;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_cmd;
  logic [16*N-1:0]  req_len;
  logic [256*N-1:0] req_payload;
  logic [N-1:0]     gnt, ack, err;
  logic [7:0]       tx_cmd;
  logic [15:0]      tx_len;
  logic [255:0]     tx_payload;
  logic             tx_send, tx_busy, active;

  packet_tx_sched #(.N(N), .MAX_LEN(ML), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GC)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_cmd(req_cmd), .req_len(req_len),
    .req_payload(req_payload), .gnt(gnt), .ack(ack), .err(err), .tx_cmd(tx_cmd),
    .tx_len(tx_len), .tx_payload(tx_payload), .tx_send(tx_send), .tx_busy(tx_busy),
    .active(active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int mptr = N - 1;

  typedef struct {
    bit           rst;
    logic [N-1:0] reqs;
    int           len;
    int           d;
    int           h;
    int           exp_w;
    bit           exp_ack;
    int           exp_end;
  } vec_t;

  task automatic check(input string name, input logic [279:0] act, input logic [279:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      req_cmd[8*i +: 8]         = 8'($urandom);
      req_len[16*i +: 16]       = 16'($urandom);
      req_payload[256*i +: 256] = rand256();
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_ctl"}, 280'({gnt, ack, err, tx_send, active}), 280'(0));
    check({name, "_tx"}, 280'({tx_cmd, tx_len, tx_payload}), 280'(0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    tx_busy = 1'b0;
    step();
    step();
    check_idle_zero("reset");
    reset_n = 1'b1;
    step();
    mptr = N - 1;
  endtask

  // Transaction-level model: winner by round robin, outcome and cycle of ack/err from timing rules.
  task automatic do_txn(input logic [N-1:0] reqs, input int len, input int d, input int h,
                        input bit drop, output int obs_w, output int obs_end, output bit obs_ack);
    int w, end_rel, last, idx;
    bit reject, ok;
    logic [N-1:0] oh, eg, ea, ee;
    logic [7:0] lc;
    logic [15:0] ll;
    logic [255:0] lp;
    req = reqs;
    scramble();
    for (int i = 0; i < N; i++) req_len[16*i +: 16] = 16'(len);
    w = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (mptr + k) % N;
      if (w < 0 && reqs[idx]) w = idx;
    end
    mptr    = w;
    oh      = '0;
    oh[w]   = 1'b1;
    lc      = req_cmd[8*w +: 8];
    ll      = req_len[16*w +: 16];
    lp      = req_payload[256*w +: 256];
    reject  = len > ML;
    ok      = !reject && d >= 1 && d <= BT;
    end_rel = reject ? 1 : (ok ? d + h + 2 : BT + 2);
    last    = end_rel + G + 1;
    obs_w = -1; obs_end = -1; obs_ack = 1'b0;
    for (int rel = 1; rel <= last; rel++) begin
      step();
      tx_busy = !reject && d >= 1 && rel >= 1 + d && rel <= d + h;
      scramble();
      if (drop && rel == 2) req[w] = 1'b0;
      eg = (rel <= end_rel) ? oh : '0;
      ea = (rel == end_rel && ok) ? oh : '0;
      ee = (rel == end_rel && !ok) ? oh : '0;
      check("ctl", 280'({gnt, ack, err, tx_send, active}),
            280'({eg, ea, ee, (!reject && rel == 1), (rel <= end_rel + G)}));
      check("tx", 280'({tx_cmd, tx_len, tx_payload}), 280'({lc, ll, lp}));
      for (int i = 0; i < N; i++) if (gnt[i] && obs_w < 0) obs_w = i;
      if ((ack | err) != '0 && obs_end < 0) begin
        obs_end = rel;
        obs_ack = |ack;
      end
      if (rel == end_rel) req[w] = 1'b0;
    end
    tx_busy = 1'b0;
  endtask

  vec_t tbl[13];
  int ow, oe;
  bit oa;

  initial begin
    reset_n = 1'b0; req = '0; tx_busy = 1'b0;
    req_cmd = '0; req_len = '0; req_payload = '0;

    tbl[0]  = '{1, 4'b0001, 32,  2, 300, 0, 1, 304};
    tbl[1]  = '{1, 4'b1111,  5,  1,   3, 0, 1,   6};
    tbl[2]  = '{0, 4'b1110,  5,  4,   2, 1, 1,   8};
    tbl[3]  = '{0, 4'b1100,  0,  2,   1, 2, 1,   5};
    tbl[4]  = '{0, 4'b1000,  7,  3,   2, 3, 1,   7};
    tbl[5]  = '{0, 4'b1111, 20,  1,   1, 0, 1,   4};
    tbl[6]  = '{0, 4'b1110,  9,  2,   2, 1, 1,   6};
    tbl[7]  = '{0, 4'b1100, 12,  5,   3, 2, 1,  10};
    tbl[8]  = '{0, 4'b0100, 33,  2,   2, 2, 0,   1};
    tbl[9]  = '{0, 4'b1000,  0,  3,   1, 3, 1,   6};
    tbl[10] = '{0, 4'b0010,  8,  0,   0, 1, 0,  18};
    tbl[11] = '{0, 4'b0001,  1, 16,   2, 0, 1,  20};
    tbl[12] = '{0, 4'b0010,  4, 17,   2, 1, 0,  18};

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) do_reset();
      do_txn(tbl[i].reqs, tbl[i].len, tbl[i].d, tbl[i].h, 1'b0, ow, oe, oa);
      check($sformatf("tbl%0d_winner", i), 280'(ow), 280'(tbl[i].exp_w));
      check($sformatf("tbl%0d_outcome", i), 280'({oa, 16'(oe)}), 280'({tbl[i].exp_ack, 16'(tbl[i].exp_end)}));
    end

    for (int t = 0; t < 40; t++) begin
      do_txn(N'($urandom_range(1, (1 << N) - 1)),
             ($urandom % 4 == 0) ? $urandom_range(33, 40) : $urandom_range(0, 32),
             $urandom_range(1, 18), $urandom_range(1, 6), 1'($urandom), ow, oe, oa);
    end

    // Reset asserted while the transmitter is busy inside WAIT_END.
    req = 4'b0001;
    scramble();
    req_len[15:0] = 16'd10;
    for (int rel = 1; rel <= 5; rel++) begin
      step();
      tx_busy = rel >= 3;
    end
    check("pre_reset_ctl", 280'({gnt, active}), 280'({4'b0001, 1'b1}));
    reset_n = 1'b0;
    #1;
    check_idle_zero("async_reset");
    step();
    check_idle_zero("held_reset");
    reset_n = 1'b1;
    tx_busy = 1'b0;
    req = 4'b0011;
    step();
    check("post_reset_gnt", 280'({gnt, tx_send, active}), 280'({4'b0001, 1'b1, 1'b1}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
